xmem_feed_ctrl: RTL and testbench

// Sequencer for the image memory read port. On a start command from the picoRV32

---
 rtl/xmem_feed_ctrl.sv | 119 +++++++++++
 tb/tb_xmem_feed_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_feed_ctrl.sv
// Image memory read sequencer: walks ctr1 from base over length words and
// streams each read word through a one-entry valid/ready stage to the accelerator.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; err pulses on an oversize length
// FEED  | loading words into the output stage while it has a free slot
// DRAIN | all words loaded, waiting for the last one to be accepted
// DONE  | run complete; done pulses on the following cycle
module xmem_feed_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [31:0]       ctr1,
    input  logic [DATA_W-1:0] xdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              slot_free;

    assign slot_free = !out_valid || out_ready;
    assign ctr1      = {{(32 - ADDR_W){1'b0}}, addr};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort wins over a coincident start
                    if (start && !abort) begin
                        if (length > DEPTH_L) begin
                            err <= 1'b1;
                        end else if (length == '0) begin
                            state <= S_DONE;
                        end else begin
                            addr      <= base_addr;
                            remaining <= length;
                            busy      <= 1'b1;
                            state     <= S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (slot_free) begin
                        out_data  <= xdata;
                        out_valid <= 1'b1;
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // the pulse stands even if abort arrives in this cycle
                    done      <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xmem_feed_ctrl.sv
// Bench for xmem_feed_ctrl: directed runs plus randomized runs checked against
// an expected word queue built from base/length and the memory image.
module tb_xmem_feed_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [31:0] ctr1;
    logic [31:0] xdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    assign xdata = mem[ctr1[9:0]];

    always #5 clk = ~clk;

    xmem_feed_ctrl #(.ADDR_W(10), .DATA_W(32), .LEN_W(11)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .ctr1      (ctr1),
        .xdata     (xdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: repeating 1,0,0,1, 2: random
    function automatic logic ready_for(input int mode, input int cyc);
        int ph;
        ph = cyc % 4;
        if (mode == 0) return 1'b1;
        if (mode == 1) return (ph == 0 || ph == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run(input logic [9:0] b, input int l, input int mode, input string tag);
        logic [31:0] expq [$];
        logic [31:0] c_before;
        logic [31:0] prev_data;
        logic        prev_stall;
        int cyc, acc, bad, extra, dones, done_cyc, first_v, errs, stall_bad, zero_bad, budget;
        for (int i = 0; i < l; i++) expq.push_back(mem[(int'(b) + i) % DEPTH]);
        c_before = ctr1;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = 11'(l);
        cyc = 0;
        out_ready = ready_for(mode, cyc);
        acc = 0; bad = 0; extra = 0; dones = 0; done_cyc = -1; first_v = -1;
        errs = 0; stall_bad = 0; zero_bad = 0; prev_stall = 1'b0; prev_data = '0;
        budget = 4 * l + 60;
        while (cyc < budget && !(dones > 0 && cyc > done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            out_ready = ready_for(mode, cyc);
            if (cyc == 1) begin
                check({tag, " busy@1"}, 64'(busy), 64'(l != 0));
                check({tag, " ctr1@1"}, 64'(ctr1), (l != 0) ? 64'(b) : 64'(c_before));
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (prev_stall && out_data !== prev_data) stall_bad++;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) extra++;
                else begin
                    if (out_data !== expq[0]) bad++;
                    void'(expq.pop_front());
                    acc++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin dones++; done_cyc = cyc; end
            if (err) errs++;
            if (l == 0 && (busy || out_valid)) zero_bad++;
        end
        check({tag, " accepted"}, 64'(acc), 64'(l));
        check({tag, " data order"}, 64'(bad), 64'd0);
        check({tag, " extra words"}, 64'(extra), 64'd0);
        check({tag, " done pulses"}, 64'(dones), 64'd1);
        check({tag, " err pulses"}, 64'(errs), 64'd0);
        check({tag, " stall stable"}, 64'(stall_bad), 64'd0);
        check({tag, " final ctr1"}, 64'(ctr1),
              (l == 0) ? 64'(c_before) : 64'((int'(b) + l) % DEPTH));
        if (l == 0) check({tag, " idle during len0"}, 64'(zero_bad), 64'd0);
        if (mode == 0) begin
            check({tag, " done cycle"}, 64'(done_cyc), (l == 0) ? 64'd2 : 64'(l + 3));
            check({tag, " first valid"}, 64'(first_v), (l == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd2);
        end
        check({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    task automatic idle_probe(input logic ab, input logic [10:0] l, input int exp_err_cyc,
                              input string tag);
        logic [31:0] c0;
        int errs, ecyc, other;
        c0 = ctr1;
        @(negedge clk);
        start = 1'b1; abort = ab; base_addr = 10'h155; length = l; out_ready = 1'b1;
        errs = 0; ecyc = -1; other = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (err) begin errs++; ecyc = c; end
            if (busy || out_valid || done) other++;
            if (ctr1 !== c0) other++;
        end
        check({tag, " err pulses"}, 64'(errs), (exp_err_cyc > 0) ? 64'd1 : 64'd0);
        check({tag, " err cycle"}, 64'(ecyc), 64'(exp_err_cyc));
        check({tag, " other outputs"}, 64'(other), 64'd0);
    endtask

    initial begin
        logic [31:0] c4;
        int acc, bad, quiet_bad;
        for (int a = 0; a < DEPTH; a++) mem[a] = 32'(a);
        resetn = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        #1;
        check("reset outputs", {ctr1, out_data}, 64'd0);
        check("reset flags", {60'd0, out_valid, busy, done, err}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("idle after reset", {59'd0, out_valid, busy, done, err, 1'b0}, 64'd0);

        run(10'h010, 4, 0, "basic");
        run(10'h010, 4, 1, "toggle");
        run(10'h3FE, 4, 0, "wrap");
        run(10'h0AA, 0, 0, "len0");
        idle_probe(1'b0, 11'd1025, 1, "len1025");
        idle_probe(1'b1, 11'd4, -1, "start+abort");

        // abort after two accepted words of an eight-word run
        @(negedge clk);
        start = 1'b1; base_addr = 10'h020; length = 11'd8; out_ready = 1'b1;
        acc = 0; bad = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_ready) begin
                if (out_data !== mem[10'h020 + acc]) bad++;
                acc++;
            end
        end
        check("abort pre accepted", 64'(acc), 64'd2);
        check("abort pre data", 64'(bad), 64'd0);
        @(negedge clk);
        out_ready = 1'b0; abort = 1'b1;
        c4 = ctr1;
        @(negedge clk);
        abort = 1'b0;
        check("abort valid", 64'(out_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort ctr1 hold", 64'(ctr1), 64'(c4));
        quiet_bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || out_valid || busy) quiet_bad++;
        end
        check("abort no done", 64'(quiet_bad), 64'd0);
        run(10'h040, 5, 0, "after abort");

        // asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1; base_addr = 10'h100; length = 11'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrun reset data", {ctr1, out_data}, 64'd0);
        check("midrun reset flags", {60'd0, out_valid, busy, done, err}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || out_valid || busy || err || ctr1 != 0) quiet_bad++;
        end
        check("midrun reset quiet", 64'(quiet_bad), 64'd0);

        // randomized runs over a random memory image
        for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
        for (int r = 0; r < 6; r++) begin
            run(10'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, "random");
        end
        run(10'($urandom_range(0, DEPTH - 1)), DEPTH, 0, "full depth");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
